ifetch_line_buffer: RTL and testbench
=====================================

Name: ifetch_line_buffer

Overview:
- Responder for the instruction-fetch port driven by the IF stage.
- Holds one 256-bit instruction line and returns 32-bit words combinationally on a hit.
- On a miss, issues a 4-beat burst read to physical memory, fills the line, then serves the fetch.
- Sits between IF and the memory arbiter/cacheline side; it is the checkpoint-2 replacement for magic instruction memory.

Parameters:
- ADDR_W, 32, byte address width
- BEAT_W, 64, physical memory data beat width
- BEATS, 4, beats per line (line = BEAT_W*BEATS = 256 bits)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_read  in  1  fetch request; held by IF until imem_resp
- imem_address  in  ADDR_W  fetch byte address; held with imem_read
- imem_rdata  out  32  fetched instruction word
- imem_resp  out  1  fetch complete this cycle
- flush_i  in  1  single-cycle pulse invalidating the line (fence.i / self-modify)
- pmem_read  out  1  burst read request to memory
- pmem_address  out  ADDR_W  line-aligned burst address
- pmem_rdata  in  BEAT_W  burst beat data
- pmem_resp  in  1  beat valid; 4 pulses per burst, not necessarily consecutive

Behaviour:
- Decided interface: one clock, clk; reset rst is asynchronous and active-high.
- State: valid bit, tag = addr[31:5], line[255:0], beat counter (2 bits), FSM {IDLE, FILL}.
- Reset values:
  - valid=0, tag=0, line=0, counter=0, state=IDLE.
  - imem_resp=0, imem_rdata=0, pmem_read=0, pmem_address=0.
- Hit = valid && tag==imem_address[31:5] && state==IDLE && !flush_i.
- Hit response, zero-cycle:
  - imem_resp=1 and imem_rdata=line[32*addr[4:2] +: 32] in the same cycle as imem_read.
  - addr[1:0] are ignored.
  - When imem_resp=0, imem_rdata is driven to 0.
- IDLE -> FILL on imem_read && !hit:
  - Register pmem_address={imem_address[31:5],5'b0}; counter=0.
- FILL:
  - pmem_read=1 (registered, held high through the burst).
  - Each cycle with pmem_resp=1: line[64*counter +: 64]=pmem_rdata; counter++.
  - On the beat with counter==3: valid=1, tag=pmem_address[31:5], pmem_read=0 next cycle, state->IDLE.
- Miss latency: request cycle + 4 beats + 1 cycle. imem_resp asserts in the first IDLE cycle after the last beat, as a hit.
- imem_resp is never asserted during FILL.
- pmem_resp outside FILL is ignored.
- imem_read dropped or address changed mid-FILL: the burst still completes and the line is installed. Requests are re-evaluated in IDLE.
- flush_i:
  - In IDLE: valid=0 next cycle; no hit is reported in the flush cycle.
  - In FILL: the burst completes, but valid stays 0 at completion (sticky pending-flush bit, cleared on return to IDLE).
- flush_i coincident with the last beat: valid=0.
- Reset mid-FILL: returns to the reset state immediately, abandons the burst, and drops pmem_read asynchronously. Memory tolerates an abandoned burst.
- Back-to-back hits: one response per cycle while imem_read is held and addresses stay within the line.

Decomposition:
- Shared package rv32i_types:
  - ifetch_state_t enum {IDLE, FILL}.
  - Constants LINE_W=256, OFFSET_W=5, WORD_SEL_MSB=4.
  - Typedef rv32i_word is already present.
- One sub-module, ifetch_line_store: line/tag/valid registers with a beat-write port and a word-read mux.
- The top level holds the FSM and the counter.

Test Plan:
- Cold miss:
  - Stimulus: reset, then imem_read=1, addr=0x60000000; memory returns beats 0x1111_1111_0000_0013, 0x..., with one 2-cycle gap.
  - Required: pmem_read=1 with pmem_address=0x60000000; exactly 4 beats accepted; imem_resp=1 one cycle after the 4th beat with rdata=0x00000013.
- Hits after the fill:
  - Stimulus: addresses 0x60000004, then 0x6000001C.
  - Required: imem_resp in the same cycle; rdata equals the upper half of beat 0 and the upper half of beat 3 respectively; pmem_read stays 0.
- Line replacement:
  - Stimulus: addr=0x60000020.
  - Required: miss; pmem_address=0x60000020; the old line is replaced; a later fetch to 0x60000000 misses again.
- Flush:
  - Stimulus: flush_i pulse in IDLE, then a fetch to 0x60000020.
  - Required: miss and refill.
  - Stimulus: flush_i mid-FILL.
  - Required: after completion no imem_resp is given; a refill starts because valid=0.
- Reset mid-FILL:
  - Stimulus: assert rst after beat 2.
  - Required: pmem_read=0 and imem_resp=0 immediately; after release, a fetch to the same address performs a full 4-beat refill.
- Unaligned/odd inputs:
  - Stimulus: addr=0x60000007.
  - Required: returns the word at 0x60000004.
  - Stimulus: a stray pmem_resp in IDLE.
  - Required: no state change.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types and line-buffer geometry used by the instruction-fetch path.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } ifetch_state_t;

   localparam int LINE_W       = 256;
   localparam int OFFSET_W     = 5;
   localparam int WORD_SEL_MSB = 4;

endpackage

// File: rtl/ifetch_line_store.sv
// Single-line instruction store: valid/tag/data registers, beat-wide write port
// and a combinational 32-bit word read mux.
module ifetch_line_store
   import rv32i_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         beat_we,
   input  logic [$clog2(BEATS)-1:0]     beat_idx,
   input  logic [BEAT_W-1:0]            beat_data,
   input  logic                         install,
   input  logic                         install_valid,
   input  logic [ADDR_W-OFFSET_W-1:0]   install_tag,
   input  logic                         inv,
   input  logic [WORD_SEL_MSB-2:0]      word_sel,
   output logic                         valid,
   output logic [ADDR_W-OFFSET_W-1:0]   tag,
   output rv32i_word                    word
);

   logic [BEAT_W*BEATS-1:0] line;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         line  <= '0;
      end else begin
         if (beat_we)
            line[beat_idx*BEAT_W +: BEAT_W] <= beat_data;
         if (install)
            tag <= install_tag;
         // Invalidate wins over a coincident install so a flush is never lost.
         if (inv)
            valid <= 1'b0;
         else if (install)
            valid <= install_valid;
      end
   end

   assign word = line[word_sel*32 +: 32];

endmodule

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch responder: one-line buffer with zero-cycle hits and a
// 4-beat burst refill from physical memory on a miss.
module ifetch_line_buffer
   import rv32i_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_read,
   input  logic [ADDR_W-1:0] imem_address,
   output rv32i_word         imem_rdata,
   output logic              imem_resp,
   input  logic              flush_i,
   output logic              pmem_read,
   output logic [ADDR_W-1:0] pmem_address,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int CNT_W = $clog2(BEATS);
   localparam int TAG_W = ADDR_W - OFFSET_W;

   ifetch_state_t    state, state_next;
   logic [CNT_W-1:0] count;
   logic             flush_pend;
   logic             valid;
   logic [TAG_W-1:0] tag;
   rv32i_word        word;
   logic             hit, start_fill, beat_take, last_beat;

   assign hit        = valid && (tag == imem_address[ADDR_W-1:OFFSET_W])
                       && (state == IDLE) && !flush_i;
   assign start_fill = (state == IDLE) && imem_read && !hit;
   assign beat_take  = (state == FILL) && pmem_resp;
   assign last_beat  = beat_take && (count == CNT_W'(BEATS-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_fill) state_next = FILL;
         FILL: if (last_beat)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pmem_read  = (state == FILL);
      imem_resp  = imem_read && hit;
      imem_rdata = imem_resp ? word : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         pmem_address <= '0;
         flush_pend   <= 1'b0;
      end else begin
         if (start_fill) begin
            pmem_address <= {imem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            count        <= '0;
         end else if (beat_take) begin
            count <= count + 1'b1;
         end
         // A flush seen during the burst must keep the arriving line invalid.
         if (state == IDLE)
            flush_pend <= 1'b0;
         else if (flush_i)
            flush_pend <= 1'b1;
      end
   end

   ifetch_line_store #(
      .ADDR_W (ADDR_W),
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
   ) u_store (
      .clk           (clk),
      .rst           (rst),
      .beat_we       (beat_take),
      .beat_idx      (count),
      .beat_data     (pmem_rdata),
      .install       (last_beat),
      .install_valid (!(flush_pend || flush_i)),
      .install_tag   (pmem_address[ADDR_W-1:OFFSET_W]),
      .inv           (flush_i),
      .word_sel      (imem_address[WORD_SEL_MSB:2]),
      .valid         (valid),
      .tag           (tag),
      .word          (word)
   );

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Self-checking bench for ifetch_line_buffer: a word-array reference model of
// the single line plus a memory responder with random beat gaps.
module tb_ifetch_line_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        flush_i;
   logic        pmem_read;
   logic [31:0] pmem_address;
   logic [63:0] pmem_rdata;
   logic        pmem_resp;

   int checks = 0;
   int errors = 0;

   // Reference model: one line held as eight 32-bit words.
   bit          m_valid;
   logic [26:0] m_tag;
   logic [31:0] m_line [8];
   int          gen = 0;

   ifetch_line_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .imem_read    (imem_read),
      .imem_address (imem_address),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .flush_i      (flush_i),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] beat_val(input logic [31:0] la, input int k, input int g);
      logic [31:0] lo, hi;
      if (la == 32'h6000_0000 && k == 0) return 64'h1111_1111_0000_0013;
      lo = la + 32'(k * 8) + 32'(g) * 32'h0101_0001;
      hi = ~lo ^ 32'h5A5A_0000 ^ 32'(k);
      return {hi, lo};
   endfunction

   task automatic model_clear();
      m_valid = 1'b0;
      m_tag   = '0;
      for (int i = 0; i < 8; i++) m_line[i] = '0;
   endtask

   // One fetch held until served; handles misses, flush during fill and reset mid-fill.
   task automatic fetch(input logic [31:0] a, input int maxgap, input int gap2_beat,
                        input int flush_beat, input int rst_beat);
      logic [31:0] la;
      logic [63:0] b;
      bit          exp_hit, flushed;
      int          gap;
      la = {a[31:5], 5'b0};
      imem_read = 1'b1;
      imem_address = a;
      for (int round = 0; round < 3; round++) begin
         exp_hit = m_valid && (m_tag == a[31:5]);
         #2;
         if (exp_hit) begin
            checks++;
            if (imem_resp !== 1'b1 || imem_rdata !== m_line[a[4:2]]) begin
               errors++;
               $display("FAIL hit_resp addr=%h: resp=%b rdata=%h, required resp=1 rdata=%h",
                        a, imem_resp, imem_rdata, m_line[a[4:2]]);
            end
            checks++;
            if (pmem_read !== 1'b0) begin
               errors++;
               $display("FAIL hit_no_pmem addr=%h: pmem_read=%b, required 0", a, pmem_read);
            end
            @(posedge clk); #1;
            imem_read = 1'b0;
            return;
         end
         checks++;
         if (imem_resp !== 1'b0 || imem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL miss_no_resp addr=%h: resp=%b rdata=%h, required 0/0", a, imem_resp, imem_rdata);
         end
         @(posedge clk); #1;
         checks++;
         if (pmem_read !== 1'b1 || pmem_address !== la) begin
            errors++;
            $display("FAIL burst_start addr=%h: pmem_read=%b pmem_address=%h, required 1 %h",
                     a, pmem_read, pmem_address, la);
         end
         flushed = 1'b0;
         for (int k = 0; k < 4; k++) begin
            gap = (k == gap2_beat) ? 2 : $urandom_range(0, maxgap);
            repeat (gap) begin
               #2;
               checks++;
               if (imem_resp !== 1'b0 || pmem_read !== 1'b1) begin
                  errors++;
                  $display("FAIL fill_gap addr=%h beat=%0d: resp=%b pmem_read=%b, required 0 1",
                           a, k, imem_resp, pmem_read);
               end
               @(posedge clk); #1;
            end
            b = beat_val(la, k, gen);
            pmem_resp = 1'b1;
            pmem_rdata = b;
            if (k == flush_beat && round == 0) begin
               flush_i = 1'b1;
               flushed = 1'b1;
            end
            m_line[2*k]   = b[31:0];
            m_line[2*k+1] = b[63:32];
            #2;
            checks++;
            if (imem_resp !== 1'b0) begin
               errors++;
               $display("FAIL fill_beat_resp addr=%h beat=%0d: resp=%b, required 0", a, k, imem_resp);
            end
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            flush_i = 1'b0;
            pmem_rdata = {$urandom, $urandom};
            if (k == rst_beat && round == 0) begin
               rst = 1'b1;
               #1;
               checks++;
               if (pmem_read !== 1'b0 || imem_resp !== 1'b0) begin
                  errors++;
                  $display("FAIL reset_mid_fill: pmem_read=%b resp=%b, required 0 0", pmem_read, imem_resp);
               end
               imem_read = 1'b0;
               model_clear();
               @(posedge clk); #1;
               rst = 1'b0;
               return;
            end
         end
         m_valid = !flushed;
         m_tag = a[31:5];
         gen++;
         checks++;
         if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL burst_end addr=%h: pmem_read=%b after 4 beats, required 0", a, pmem_read);
         end
      end
      errors++;
      $display("FAIL fetch_unresolved addr=%h: no response after refills, required response", a);
      imem_read = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      imem_read = 1'b0;
      imem_address = 32'h6000_0000;
      flush_i = 1'b0;
      pmem_rdata = '0;
      pmem_resp = 1'b0;
      model_clear();
      #3;
      checks++;
      if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: resp=%b rdata=%h pmem_read=%b pmem_address=%h, required all 0",
                  imem_resp, imem_rdata, pmem_read, pmem_address);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_cold_miss_and_hits();
      fetch(32'h6000_0000, 0, 2, -1, -1);
      fetch(32'h6000_0004, 0, -1, -1, -1);
      fetch(32'h6000_001C, 0, -1, -1, -1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      imem_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = {5'b0_1100, 22'h0, 3'(i), 2'($urandom_range(0, 3))} | 32'h6000_0000;
         a[31:5] = 27'(32'h6000_0020 >> 5);
         imem_address = a;
         #2;
         checks++;
         if (imem_resp !== 1'b1 || imem_rdata !== m_line[a[4:2]] || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back addr=%h: resp=%b rdata=%h pmem_read=%b, required 1 %h 0",
                     a, imem_resp, imem_rdata, pmem_read, m_line[a[4:2]]);
         end
         @(posedge clk); #1;
      end
      imem_read = 1'b0;
   endtask

   task automatic test_replacement();
      fetch(32'h6000_0020, 1, -1, -1, -1);
      test_back_to_back();
      fetch(32'h6000_0000, 1, -1, -1, -1);
   endtask

   task automatic flush_idle();
      flush_i = 1'b1;
      #2;
      checks++;
      if (imem_resp !== 1'b0 || pmem_read !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: resp=%b pmem_read=%b, required 0 0", imem_resp, pmem_read);
      end
      @(posedge clk); #1;
      flush_i = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic test_flush();
      fetch(32'h6000_0020, 1, -1, -1, -1);
      flush_idle();
      fetch(32'h6000_0020, 1, -1, -1, -1);
      fetch(32'h6000_0040, 2, -1, 1, -1);
      fetch(32'h6000_0060, 1, -1, 3, -1);
   endtask

   task automatic test_reset_mid_fill();
      fetch(32'h6000_0080, 1, -1, -1, 1);
      fetch(32'h6000_0080, 1, -1, -1, -1);
      fetch(32'h6000_0088, 0, -1, -1, -1);
   endtask

   task automatic test_unaligned_stray();
      fetch(32'h6000_0000, 1, -1, -1, -1);
      fetch(32'h6000_0007, 0, -1, -1, -1);
      for (int i = 0; i < 3; i++) begin
         pmem_resp = 1'b1;
         pmem_rdata = {$urandom, $urandom};
         #2;
         checks++;
         if (pmem_read !== 1'b0 || imem_resp !== 1'b0) begin
            errors++;
            $display("FAIL stray_pmem_resp: pmem_read=%b resp=%b, required 0 0", pmem_read, imem_resp);
         end
         @(posedge clk); #1;
      end
      pmem_resp = 1'b0;
      for (int w = 0; w < 8; w++) fetch(32'h6000_0000 + 32'(w * 4), 0, -1, -1, -1);
   endtask

   task automatic test_random();
      logic [31:0] lines [4];
      logic [31:0] a;
      int          fb;
      lines[0] = 32'h6000_0000;
      lines[1] = 32'h6000_0020;
      lines[2] = 32'h6000_0040;
      lines[3] = 32'h7000_0000;
      for (int i = 0; i < 40; i++) begin
         a = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
         fb = $urandom_range(0, 11);
         if ($urandom_range(0, 9) == 0) flush_idle();
         fetch(a, 3, -1, fb, -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss_and_hits();
      test_replacement();
      test_flush();
      test_reset_mid_fill();
      test_unaligned_stray();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
